sar_adc_mc: RTL and testbench

SAR_ADC_MC -- requirements
Module: sar_adc_mc

---
 rtl/sar_adc_pkg.sv | 18 +
 rtl/sar_adc_trial.sv | 81 ++++++++
 rtl/sar_adc_mc.sv | 171 +++++++++++++++++
 tb/tb_sar_adc_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types for the multi-channel SAR ADC controller: sequencer states and
// the channel-index width helper.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StTrial,
    StAcc,
    StOut
  } sar_state_e;

  // A single-channel build still needs a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_trial.sv
// Bit-trial engine: walks the DAC code MSB to LSB, one bit per SETTLE_CYC+1 cycles,
// started by go and reporting fin on the cycle the LSB decision is made.
module sar_adc_trial
  import sar_adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 cmp,
  output logic [ADC_WIDTH-1:0] dac,
  output logic [ADC_WIDTH-1:0] result,
  output logic                 fin
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned BitW = $clog2(ADC_WIDTH);

  logic                 active_q, active_d;
  logic [BitW-1:0]      bit_q, bit_d, bit_dec;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0] dac_q, dac_d, result_q, result_d, kept;
  logic                 slot_end;

  always_comb begin
    slot_end = active_q && (cnt_q == CntW'(SETTLE_CYC));
    fin      = slot_end && (bit_q == '0);
    bit_dec  = bit_q - 1'b1;
    kept     = dac_q;
    if (slot_end && !cmp) kept[bit_q] = 1'b0;

    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    result_d = result_q;

    if (go) begin
      active_d             = 1'b1;
      bit_d                = BitW'(ADC_WIDTH - 1);
      cnt_d                = '0;
      dac_d                = '0;
      dac_d[ADC_WIDTH-1]   = 1'b1;
    end else if (active_q) begin
      if (fin) begin
        active_d = 1'b0;
        dac_d    = '0;
        result_d = kept;
      end else if (slot_end) begin
        bit_d          = bit_dec;
        cnt_d          = '0;
        dac_d          = kept;
        dac_d[bit_dec] = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      cnt_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      result_q <= result_d;
    end
  end

  assign dac    = dac_q;
  assign result = result_q;

endmodule

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC sequencer: scans masked channels in ascending order.
// Define SAR_ADC_MC_AVG_EN to average 2^AVG_LOG2 passes per channel.
module sar_adc_mc
  import sar_adc_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 8,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CH_NUM-1:0]             ch_mask,
  input  logic                          cmp,
  output logic [ch_idx_w(CH_NUM)-1:0]   mux_sel,
  output logic [ADC_WIDTH-1:0]          DACF,
  output logic                          busy,
  output logic                          eoc,
  output logic                          den,
  output logic [ADC_WIDTH-1:0]          Dout,
  output logic [ch_idx_w(CH_NUM)-1:0]   Dch,
  output logic                          done
);

`ifdef SAR_ADC_MC_AVG_EN
  localparam int unsigned AvgShift = AVG_LOG2;
`else
  localparam int unsigned AvgShift = 0;
`endif
  localparam int unsigned ChW   = ch_idx_w(CH_NUM);
  localparam int unsigned AccW  = ADC_WIDTH + AvgShift;
  localparam int unsigned PassW = AvgShift + 1;
  localparam int unsigned CntW  = $clog2(SETTLE_CYC + 1);

  sar_state_e           state_q, state_d;
  logic                 start_q;
  logic [CH_NUM-1:0]    mask_q, mask_d;
  logic [ChW-1:0]       ch_q, ch_d, dch_q, dch_d, first_idx, next_idx;
  logic [CntW-1:0]      settle_q, settle_d;
  logic [PassW-1:0]     pass_q, pass_d;
  logic [AccW-1:0]      acc_q, acc_d, sum;
  logic [ADC_WIDTH-1:0] dout_q, dout_d, result;
  logic                 den_q, den_d, next_found, go, fin;

  sar_adc_trial #(
    .ADC_WIDTH (ADC_WIDTH),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_trial (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .cmp   (cmp),
    .dac   (DACF),
    .result(result),
    .fin   (fin)
  );

  // Descending loops so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_idx = ChW'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_idx   = ChW'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    den_d    = den_q;
    go       = 1'b0;
    sum      = acc_q + AccW'(result);

    unique case (state_q)
      StIdle: begin
        if (start && !start_q && (|ch_mask)) begin
          state_d  = StSettle;
          mask_d   = ch_mask;
          ch_d     = first_idx;
          settle_d = '0;
          pass_d   = '0;
          acc_d    = '0;
          den_d    = 1'b0;
        end
      end
      StSettle: begin
        if (settle_q == CntW'(SETTLE_CYC - 1)) begin
          state_d = StTrial;
          go      = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StTrial: begin
        if (fin) state_d = StAcc;
      end
      StAcc: begin
        if (pass_q == PassW'((1 << AvgShift) - 1)) begin
          state_d = StOut;
          dout_d  = ADC_WIDTH'(sum >> AvgShift);
          dch_d   = ch_q;
          den_d   = 1'b1;
          acc_d   = '0;
          pass_d  = '0;
        end else begin
          state_d = StTrial;
          acc_d   = sum;
          pass_d  = pass_q + 1'b1;
          go      = 1'b1;
        end
      end
      StOut: begin
        if (next_found) begin
          state_d  = StSettle;
          ch_d     = next_idx;
          settle_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      mask_q   <= '0;
      ch_q     <= '0;
      settle_q <= '0;
      pass_q   <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      dch_q    <= '0;
      den_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
      den_q    <= den_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign eoc     = (state_q == StOut);
  assign done    = eoc && !next_found;
  assign mux_sel = ch_q;
  assign Dout    = dout_q;
  assign Dch     = dch_q;
  assign den     = den_q;

endmodule

// File: tb/tb_sar_adc_mc.sv
// Bench for sar_adc_mc: ideal analog model (cmp = Vin[mux_sel] >= DACF) and a
// timing/result model derived from scan order, pass count and settle length.
module tb_sar_adc_mc;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 1;
  localparam int A = 2;
`ifdef SAR_ADC_MC_AVG_EN
  localparam int P = 1 << A;
`else
  localparam int P = 1;
`endif
  localparam int PASS_LEN = W * (S + 1) + 1;
  localparam int LAT = S + P * PASS_LEN;

  logic       clk = 1'b0;
  logic       rst, start, cmp;
  logic [3:0] ch_mask;
  logic [1:0] mux_sel, Dch;
  logic [7:0] DACF, Dout;
  logic       busy, eoc, den, done;
  logic [7:0] vin [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always_comb cmp = (vin[mux_sel] >= DACF);

  sar_adc_mc #(
    .ADC_WIDTH (W),
    .CH_NUM    (N),
    .SETTLE_CYC(S),
    .AVG_LOG2  (A)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ch_mask(ch_mask),
    .cmp    (cmp),
    .mux_sel(mux_sel),
    .DACF   (DACF),
    .busy   (busy),
    .eoc    (eoc),
    .den    (den),
    .Dout   (Dout),
    .Dch    (Dch),
    .done   (done)
  );

  task automatic check_zero(input string name);
    logic [25:0] got;
    got = {busy, eoc, done, den, Dout, Dch, mux_sel, DACF};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: got %h required 0", name, got);
    end
  endtask

  // Start a scan of mask and check every cycle until two cycles past the last eoc.
  task automatic scan_check(input logic [3:0] mask, input bit glitch, input string name);
    int exp_k[$];
    int exp_ch[$];
    int last_k;
    bit hit, is_last;
    logic [7:0] cur_dout;
    logic [1:0] cur_dch;
    for (int c = 0; c < N; c++)
      if (mask[c]) begin
        exp_k.push_back(LAT + exp_ch.size() * (LAT + 1));
        exp_ch.push_back(c);
      end
    last_k = exp_k[exp_k.size()-1];
    cur_dout = '0;
    cur_dch = '0;
    ch_mask = mask;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= last_k + 2; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      hit = 1'b0;
      is_last = 1'b0;
      foreach (exp_k[i])
        if (exp_k[i] == k) begin
          hit = 1'b1;
          is_last = (i == exp_k.size() - 1);
          cur_dout = vin[exp_ch[i]];
          cur_dch = 2'(exp_ch[i]);
        end
      checks += 4;
      if (eoc !== hit) begin
        errors++; $display("FAIL %s eoc k=%0d got %b required %b", name, k, eoc, hit);
      end
      if (done !== is_last) begin
        errors++; $display("FAIL %s done k=%0d got %b required %b", name, k, done, is_last);
      end
      if (busy !== (k <= last_k)) begin
        errors++; $display("FAIL %s busy k=%0d got %b required %b", name, k, busy, k <= last_k);
      end
      if (den !== (k >= exp_k[0])) begin
        errors++; $display("FAIL %s den k=%0d got %b required %b", name, k, den, k >= exp_k[0]);
      end
      if (k >= exp_k[0]) begin
        checks += 2;
        if (Dout !== cur_dout) begin
          errors++; $display("FAIL %s Dout k=%0d got %h required %h", name, k, Dout, cur_dout);
        end
        if (Dch !== cur_dch) begin
          errors++; $display("FAIL %s Dch k=%0d got %0d required %0d", name, k, Dch, cur_dch);
        end
      end
      if (k == 0) begin
        checks += 2;
        if (DACF !== 8'h00) begin
          errors++; $display("FAIL %s settle DACF got %h required 00", name, DACF);
        end
        if (mux_sel !== 2'(exp_ch[0])) begin
          errors++; $display("FAIL %s mux_sel got %0d required %0d", name, mux_sel, exp_ch[0]);
        end
      end
      if (glitch) begin
        if (k == 5 || k == 25) begin start = 1'b1; ch_mask = 4'hF; end
        if (k == 6 || k == 26) start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ch_mask = '0;
    for (int i = 0; i < N; i++) vin[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    vin[0] = 8'hA5;
    scan_check(4'b0001, 1'b0, "single_a5");
  endtask

  task automatic test_two_channels();
    vin[1] = 8'h00; vin[3] = 8'hFF;
    scan_check(4'b1010, 1'b0, "two_ch");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) vin[i] = 8'($urandom);
      scan_check(4'($urandom_range(1, 15)), 1'b0, "random");
    end
  endtask

  task automatic test_avg();
    logic [7:0] pv [4];
    int sum;
    logic [7:0] expv;
    pv[0] = 8'h10; pv[1] = 8'h11; pv[2] = 8'h12; pv[3] = 8'h13;
    sum = 0;
    for (int p = 0; p < P; p++) sum += pv[p];
    expv = 8'(sum / P);
    vin[0] = pv[0];
    ch_mask = 4'b0001; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      for (int p = 0; p < P - 1; p++)
        if (k == S + p * PASS_LEN + PASS_LEN - 1) vin[0] = pv[p+1];
      checks += 2;
      if (eoc !== (k == LAT)) begin
        errors++; $display("FAIL avg eoc k=%0d got %b required %b", k, eoc, k == LAT);
      end
      if (done !== (k == LAT)) begin
        errors++; $display("FAIL avg done k=%0d got %b required %b", k, done, k == LAT);
      end
      if (k == LAT) begin
        checks++;
        if (Dout !== expv) begin
          errors++; $display("FAIL avg Dout got %h required %h", Dout, expv);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    ch_mask = 4'b0000; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 3) start = 1'b0;
      checks += 2;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL mask_zero busy k=%0d got %b required 0", k, busy);
      end
      if (eoc !== 1'b0) begin
        errors++; $display("FAIL mask_zero eoc k=%0d got %b required 0", k, eoc);
      end
    end
  endtask

  task automatic test_back_to_back();
    vin[0] = 8'h3C; vin[1] = 8'hC3;
    scan_check(4'b0011, 1'b1, "restart_busy");
  endtask

  task automatic test_reset_mid();
    vin[0] = 8'($urandom);
    ch_mask = 4'b0001; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_zero("mid_trial_reset");
    rst = 1'b0;
    vin[0] = 8'h5A;
    scan_check(4'b0001, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_channels();
    test_avg();
    test_mask_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
